alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid_i  input  1  upstream presents an instruction.
REQ-004 SHALL have port in_ready_o  output  1  stage can accept; transfer when in_valid_i & in_ready_o.
REQ-005 SHALL have port instr_i  input  32  RV32 instruction word.
REQ-006 SHALL have port rs1_data_i  input  32  register-file value for rs1.
REQ-007 SHALL have port rs2_data_i  input  32  register-file value for rs2.
REQ-008 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-009 SHALL have port out_valid_o  output  1  head entry valid toward ALU.
REQ-010 SHALL have port out_ready_i  input  1  ALU side consumes; transfer when out_valid_o & out_ready_i.
REQ-011 SHALL have port alu_ctrl_o  output  3  ALU control code.
REQ-012 SHALL have ports op_a_o / op_b_o  output  32 each  ALU operands.
REQ-013 SHALL have port rd_o  output  5  destination register.
REQ-014 SHALL have port reg_write_o  output  1  result writes rd.
REQ-015 SHALL have port illegal_o  output  1  instruction not decodable.

Function
REQ-016 SHALL use ALU codes: and 000, xor 001, sll 010, add 011, sub 100, mul 101, addi 110, srai 111.
REQ-017 SHALL decode opcode 0110011 by funct7/funct3: 0000000/111 and, 0000000/100 xor, 0000000/001 sll, 0000000/000 add, 0100000/000 sub, 0000001/000 mul; op_a=rs1_data, op_b=rs2_data, reg_write=1.
REQ-018 SHALL decode opcode 0010011 funct3 000 as addi: op_b = sign-extended instr[31:20], reg_write=1.
REQ-019 SHALL decode opcode 0010011 funct3 101 funct7 0100000 as srai: op_b = zero-extended instr[24:20], reg_write=1.
REQ-020 SHALL decode lw (0000011, funct3 010) as addi with I-immediate, reg_write=1; sw (0100011, funct3 010) as addi with S-immediate {instr[31:25],instr[11:7]} sign-extended, reg_write=0; beq (1100011, funct3 000) as sub with rs2_data, reg_write=0.
REQ-021 SHALL mark any other encoding illegal: illegal=1, alu_ctrl=011, op_a=op_b=0, reg_write=0; entry still flows through the buffer.
REQ-022 SHALL force reg_write=0 whenever rd = 0.
REQ-023 SHALL hold decoded entries in a 2-entry in-order buffer (main + skid), states EMPTY, ONE, TWO.
REQ-024 SHALL present an entry accepted into EMPTY on outputs the following cycle (latency 1).
REQ-025 SHALL drive in_ready_o from a register: 1 in EMPTY and ONE, 0 in TWO.
REQ-026 Transitions: EMPTY+accept->ONE; ONE+accept only->TWO; ONE+consume only->EMPTY; ONE+accept+consume->ONE (new entry becomes head); TWO+consume->ONE (skid moves to head); otherwise hold.
REQ-027 SHALL keep output payload stable while out_valid_o=1 and out_ready_i=0.
REQ-028 SHALL, on flush_i, enter EMPTY next cycle, dropping all entries including one accepted in the same cycle; flush dominates accept and consume.
REQ-029 SHALL hold payload outputs at 0 when out_valid_o=0.

Reset
REQ-030 SHALL on rst_i asynchronously enter EMPTY: out_valid_o=0, in_ready_o=1, alu_ctrl_o=000, op_a_o=op_b_o=0, rd_o=0, reg_write_o=0, illegal_o=0.
REQ-031 SHALL, when reset asserts mid-operation, discard all entries; first accept after release completes normally.

Structure
REQ-032 SHALL take ALU codes, opcode/funct3/funct7 constants and the entry struct (ctrl, op_a, op_b, rd, reg_write, illegal) from shared package alu_pkg.
REQ-033 SHALL place combinational decode in one sub-module alu_ctrl_decode; alu_issue_stage contains only buffer and state.

Verification
REQ-034 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ctrl=011, op_a=5, op_b=7, rd=3, reg_write=1.
REQ-035 srai x5,x6,3 (0x40335293), rs1=0x80000000 -> ctrl=111, op_b=3; addi x1,x0,-1 (0xFFF00093) -> ctrl=110, op_b=0xFFFFFFFF.
REQ-036 out_ready=0, push three valid instructions back-to-back -> first two accepted, in_ready=0 after second, third held; release out_ready -> outputs in original order, no loss.
REQ-037 Buffer in TWO, assert flush_i with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle instruction never appears.
REQ-038 instr 0xFFFFFFFF -> illegal=1, ctrl=011, op_a=op_b=0, reg_write=0; add x0,x1,x2 (0x00208033) -> reg_write=0.
REQ-039 Assert rst_i asynchronously while in TWO -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALU control codes, RV32 opcode/funct constants
// and the decoded entry carried through the issue buffer.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    alu_op_e     ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } entry_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32 decode of one instruction into an ALU issue entry.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output entry_t      entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    entry           = '0;
    entry.ctrl      = ALU_ADD;
    legal           = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        legal = 1'b1;
        if      (funct7 == F7_BASE && funct3 == F3_AND)     entry.ctrl = ALU_AND;
        else if (funct7 == F7_BASE && funct3 == F3_XOR)     entry.ctrl = ALU_XOR;
        else if (funct7 == F7_BASE && funct3 == F3_SLL)     entry.ctrl = ALU_SLL;
        else if (funct7 == F7_BASE && funct3 == F3_ADD_SUB) entry.ctrl = ALU_ADD;
        else if (funct7 == F7_ALT  && funct3 == F3_ADD_SUB) entry.ctrl = ALU_SUB;
        else if (funct7 == F7_MUL  && funct3 == F3_ADD_SUB) entry.ctrl = ALU_MUL;
        else legal = 1'b0;
        entry.op_b      = rs2_data;
        entry.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD_SUB) begin
          legal      = 1'b1;
          entry.ctrl = ALU_ADDI;
          entry.op_b = sext12(instr[31:20]);
        end else if (funct3 == F3_SRA && funct7 == F7_ALT) begin
          legal      = 1'b1;
          entry.ctrl = ALU_SRAI;
          entry.op_b = {27'b0, instr[24:20]};
        end
        entry.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        legal           = (funct3 == F3_WORD);
        entry.ctrl      = ALU_ADDI;
        entry.op_b      = sext12(instr[31:20]);
        entry.reg_write = 1'b1;
      end
      OPC_STORE: begin
        legal      = (funct3 == F3_WORD);
        entry.ctrl = ALU_ADDI;
        entry.op_b = sext12({instr[31:25], instr[11:7]});
      end
      OPC_BRANCH: begin
        legal      = (funct3 == F3_BEQ);
        entry.ctrl = ALU_SUB;
        entry.op_b = rs2_data;
      end
      default: legal = 1'b0;
    endcase

    entry.op_a = rs1_data;
    entry.rd   = instr[11:7];
    if (entry.rd == 5'd0) entry.reg_write = 1'b0;

    // Undecodable words collapse to a zero-operand add that writes nothing.
    if (!legal) begin
      entry           = '0;
      entry.ctrl      = ALU_ADD;
      entry.rd        = instr[11:7];
      entry.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes incoming instructions into a 2-entry in-order
// buffer (head + skid) with a registered ready toward upstream.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [2:0]  alu_ctrl_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t dec_entry;
  entry_t out_entry;
  logic   in_ready_q;
  logic   accept;
  logic   consume;

  alu_ctrl_decode u_decode (
    .instr    (instr_i),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .entry    (dec_entry)
  );

  assign out_valid_o = (state_q != S_EMPTY);
  assign in_ready_o  = in_ready_q;
  assign accept      = in_valid_i & in_ready_q;
  assign consume     = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          head_d  = dec_entry;
        end
      end
      S_ONE: begin
        if (accept && consume) begin
          head_d = dec_entry;
        end else if (accept) begin
          state_d = S_TWO;
          skid_d  = dec_entry;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (consume) begin
          state_d = S_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) state_d = S_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  assign out_entry   = out_valid_o ? head_q : '0;
  assign alu_ctrl_o  = out_entry.ctrl;
  assign op_a_o      = out_entry.op_a;
  assign op_b_o      = out_entry.op_b;
  assign rd_o        = out_entry.rd;
  assign reg_write_o = out_entry.reg_write;
  assign illegal_o   = out_entry.illegal;

endmodule
